// File: rtl/cpu_traffic_gen_if.sv
// CPU-port bundle between a request generator (master) and the cache (slave).
// Signal names follow the cache CPU-port naming so system benches can wire straight through.
interface cpu_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              Req_CPU;
  logic              Wr_CPU;
  logic [ADDR_W-1:0] A_CPU;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        Ins_Type;
  logic              Ready_Cache;
  logic [DATA_W-1:0] data_in;

  modport master (
    output Req_CPU, Wr_CPU, A_CPU, data_out, Ins_Type,
    input  Ready_Cache, data_in
  );

  modport slave (
    input  Req_CPU, Wr_CPU, A_CPU, data_out, Ins_Type,
    output Ready_Cache, data_in
  );
endinterface

// File: rtl/cpu_traffic_gen.sv
// Programmable CPU-side request generator: strided reads/writes over Req/Ready,
// optional read-back verification with a saturating mismatch counter and a stall timeout.
module cpu_traffic_gen #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REQ     = 16,
  parameter int BASE_ADDR   = 1,
  parameter int ADDR_STRIDE = 1,
  parameter int DATA_SEED   = 64,
  parameter int MODE        = 0,
  parameter int INS_TYPE    = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  cpu_traffic_gen_if.master       bus,
  output logic                    done,
  output logic                    timeout,
  output logic [15:0]             err_count
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pass_q, pass_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [1:0]         ins_q, ins_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        err_q, err_d;
  logic               load;
  logic               last_txn;
  logic               verify_rd;

  // Pass 0 writes and pass 1 reads in the combined modes.
  function automatic logic is_write(input logic pass);
    case (MODE)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return ~pass;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] k);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(k) * ADDR_W'(ADDR_STRIDE);
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [IDX_W-1:0] k);
    return DATA_W'(DATA_SEED) + DATA_W'(k);
  endfunction

  assign last_txn  = (idx_q == LAST_IDX) && ((MODE < 2) || pass_q);
  assign verify_rd = (MODE >= 2) && pass_q;

  always_comb begin
    // NOTE: every *_d takes its current value first, so paths that leave it untouched infer no latch.
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    wait_d    = wait_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ins_d     = ins_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    load      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d     = '0;
          pass_d    = 1'b0;
          err_d     = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          load      = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (bus.Ready_Cache) begin
          if (verify_rd && (bus.data_in != data_q) && (err_q != 16'hFFFF))
            err_d = err_q + 16'd1;
          req_d = 1'b0;
          ins_d = 2'b00;
          if (last_txn) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end else if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          req_d     = 1'b0;
          ins_d     = 2'b00;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_GAP: begin
        // Mode 3 pairs write/read per index; mode 2 wraps the index into the read pass.
        if (MODE == 3) begin
          pass_d = ~pass_q;
          if (pass_q) idx_d = idx_q + 1'b1;
        end else if ((MODE == 2) && (idx_q == LAST_IDX)) begin
          idx_d  = '0;
          pass_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        load    = 1'b1;
        state_d = S_REQ;
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      req_d  = 1'b1;
      wr_d   = is_write(pass_d);
      addr_d = addr_of(idx_d);
      data_d = data_of(idx_d);
      ins_d  = 2'(INS_TYPE);
      wait_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; state flops use non-blocking assignment.
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pass_q    <= 1'b0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= ADDR_W'(BASE_ADDR);
      data_q    <= DATA_W'(DATA_SEED);
      ins_q     <= 2'b00;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ins_q     <= ins_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign bus.Req_CPU  = req_q;
  assign bus.Wr_CPU   = wr_q;
  assign bus.A_CPU    = addr_q;
  assign bus.data_out = data_q;
  assign bus.Ins_Type = ins_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
// Scoreboard bench for cpu_traffic_gen: five configurations, expected transactions queued
// at start and popped by a negedge monitor on every completed request.
module tb_cpu_traffic_gen;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  ins;
    int          rel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst0 = 1'b0;
  logic        rdy0 = 1'b1;
  logic [4:0]  start = '0;
  logic [4:0]  done_w;
  logic [4:0]  to_w;
  logic [15:0] err_w [5];
  int          cyc = 0;
  int          start_cyc [5];
  int          t_req_cnt = 0;
  int          vectors = 0;
  int          errors = 0;
  txn_t        exp_q [5][$];
  logic [31:0] mem2 [16];
  logic [31:0] mem3 [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // id 0: write-only, INS_TYPE=2, controllable ready and reset
  cpu_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  cpu_traffic_gen #(.NUM_REQ(4), .INS_TYPE(2)) u0 (
    .clk(clk), .rst(rst0), .start(start[0]), .bus(b0.master),
    .done(done_w[0]), .timeout(to_w[0]), .err_count(err_w[0]));
  assign b0.Ready_Cache = rdy0;
  assign b0.data_in     = 32'd0;

  // id 1: read-only, 8-bit address wrapping past FF
  cpu_traffic_gen_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
  cpu_traffic_gen #(.ADDR_W(8), .NUM_REQ(4), .BASE_ADDR(8'hFE), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .bus(b1.master),
    .done(done_w[1]), .timeout(to_w[1]), .err_count(err_w[1]));
  assign b1.Ready_Cache = 1'b1;
  assign b1.data_in     = 32'd0;

  // id 2: write pass then read-verify pass against an echoing memory
  cpu_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  cpu_traffic_gen #(.NUM_REQ(4), .MODE(2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .bus(b2.master),
    .done(done_w[2]), .timeout(to_w[2]), .err_count(err_w[2]));
  assign b2.Ready_Cache = 1'b1;
  assign b2.data_in     = mem2[b2.A_CPU[3:0]];

  // id 3: alternating write/read, read of address 3 returns corrupted data
  cpu_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
  cpu_traffic_gen #(.NUM_REQ(4), .MODE(3)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .bus(b3.master),
    .done(done_w[3]), .timeout(to_w[3]), .err_count(err_w[3]));
  assign b3.Ready_Cache = 1'b1;
  assign b3.data_in     = (!b3.Wr_CPU && b3.A_CPU == 32'd3) ? 32'd0 : mem3[b3.A_CPU[3:0]];

  // id 4: stalled cache, short timeout
  cpu_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) b4 ();
  cpu_traffic_gen #(.NUM_REQ(4), .TIMEOUT(5)) u4 (
    .clk(clk), .rst(rst), .start(start[4]), .bus(b4.master),
    .done(done_w[4]), .timeout(to_w[4]), .err_count(err_w[4]));
  assign b4.Ready_Cache = 1'b0;
  assign b4.data_in     = 32'd0;

  always @(posedge clk) begin
    if (b2.Req_CPU && b2.Ready_Cache && b2.Wr_CPU) mem2[b2.A_CPU[3:0]] <= b2.data_out;
    if (b3.Req_CPU && b3.Ready_Cache && b3.Wr_CPU) mem3[b3.A_CPU[3:0]] <= b3.data_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] ins, input int rel);
    txn_t t;
    t = '{wr, a, d, ins, rel};
    exp_q[id].push_back(t);
  endtask

  task automatic mon(input int id, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [1:0] ins);
    txn_t  e;
    string n;
    n = $sformatf("u%0d.rel%0d", id, cyc - start_cyc[id]);
    if (exp_q[id].size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: request completed with empty scoreboard (addr %0h)", n, addr);
    end else begin
      e = exp_q[id].pop_front();
      check({n, ".wr"},    32'(wr),   32'(e.wr));
      check({n, ".addr"},  addr,      e.addr);
      check({n, ".data"},  data,      e.data);
      check({n, ".ins"},   32'(ins),  32'(e.ins));
      check({n, ".cycle"}, 32'(cyc - start_cyc[id]), 32'(e.rel));
    end
  endtask

  always @(negedge clk) begin
    if (b0.Req_CPU && b0.Ready_Cache) mon(0, b0.Wr_CPU, b0.A_CPU, b0.data_out, b0.Ins_Type);
    if (b1.Req_CPU && b1.Ready_Cache) mon(1, b1.Wr_CPU, 32'(b1.A_CPU), b1.data_out, b1.Ins_Type);
    if (b2.Req_CPU && b2.Ready_Cache) mon(2, b2.Wr_CPU, b2.A_CPU, b2.data_out, b2.Ins_Type);
    if (b3.Req_CPU && b3.Ready_Cache) mon(3, b3.Wr_CPU, b3.A_CPU, b3.data_out, b3.Ins_Type);
    if (b4.Req_CPU) t_req_cnt++;
  end

  task automatic kick(input int id);
    @(negedge clk);
    start[id]     = 1'b1;
    start_cyc[id] = cyc;
    @(negedge clk);
    start[id]     = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget, input int exp_rel);
    int n = 0;
    @(negedge clk);
    while (!done_w[id] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d.done_cycle", id), 32'(cyc - start_cyc[id]), 32'(exp_rel));
  endtask

  task automatic push_u3();
    push(3, 1'b1, 32'd1, 32'd64, 2'd0, 1);
    push(3, 1'b0, 32'd1, 32'd64, 2'd0, 3);
    push(3, 1'b1, 32'd2, 32'd65, 2'd0, 5);
    push(3, 1'b0, 32'd2, 32'd65, 2'd0, 7);
    push(3, 1'b1, 32'd3, 32'd66, 2'd0, 9);
    push(3, 1'b0, 32'd3, 32'd66, 2'd0, 11);
    push(3, 1'b1, 32'd4, 32'd67, 2'd0, 13);
    push(3, 1'b0, 32'd4, 32'd67, 2'd0, 15);
  endtask

  task automatic check_reset_u0(input string tag);
    check({tag, ".req"},  32'(b0.Req_CPU),  32'd0);
    check({tag, ".wr"},   32'(b0.Wr_CPU),   32'd0);
    check({tag, ".addr"}, b0.A_CPU,         32'd1);
    check({tag, ".data"}, b0.data_out,      32'd64);
    check({tag, ".ins"},  32'(b0.Ins_Type), 32'd0);
    check({tag, ".done"}, 32'(done_w[0]),   32'd0);
    check({tag, ".to"},   32'(to_w[0]),     32'd0);
    check({tag, ".err"},  32'(err_w[0]),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_u0("reset");
    check("reset.u1.addr", 32'(b1.A_CPU), 32'h0000_00FE);
    rst  = 1'b1;
    rst0 = 1'b1;

    // Writes every other cycle; a start pulse mid-sequence must be ignored.
    push(0, 1'b1, 32'd1, 32'd64, 2'd2, 1);
    push(0, 1'b1, 32'd2, 32'd65, 2'd2, 3);
    push(0, 1'b1, 32'd3, 32'd66, 2'd2, 5);
    push(0, 1'b1, 32'd4, 32'd67, 2'd2, 7);
    kick(0);
    @(negedge clk);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 30, 8);
    check("u0.timeout", 32'(to_w[0]), 32'd0);

    // Reads with 8-bit address wrap; no verification in read-only mode.
    push(1, 1'b0, 32'hFE, 32'd64, 2'd0, 1);
    push(1, 1'b0, 32'hFF, 32'd65, 2'd0, 3);
    push(1, 1'b0, 32'h00, 32'd66, 2'd0, 5);
    push(1, 1'b0, 32'h01, 32'd67, 2'd0, 7);
    kick(1);
    wait_done(1, 30, 8);
    check("u1.err", 32'(err_w[1]), 32'd0);

    // Write pass then read pass against echoing memory.
    push(2, 1'b1, 32'd1, 32'd64, 2'd0, 1);
    push(2, 1'b1, 32'd2, 32'd65, 2'd0, 3);
    push(2, 1'b1, 32'd3, 32'd66, 2'd0, 5);
    push(2, 1'b1, 32'd4, 32'd67, 2'd0, 7);
    push(2, 1'b0, 32'd1, 32'd64, 2'd0, 9);
    push(2, 1'b0, 32'd2, 32'd65, 2'd0, 11);
    push(2, 1'b0, 32'd3, 32'd66, 2'd0, 13);
    push(2, 1'b0, 32'd4, 32'd67, 2'd0, 15);
    kick(2);
    wait_done(2, 40, 16);
    check("u2.err", 32'(err_w[2]), 32'd0);

    // Interleaved write/read; corrupted read completes at rel 11, counted from rel 12.
    push_u3();
    kick(3);
    repeat (10) @(negedge clk);
    check("u3.err_before", 32'(err_w[3]), 32'd0);
    @(negedge clk);
    check("u3.err_after", 32'(err_w[3]), 32'd1);
    wait_done(3, 40, 16);
    check("u3.err_final", 32'(err_w[3]), 32'd1);

    // Restart from DONE clears done and err_count.
    push_u3();
    kick(3);
    check("u3.restart.done", 32'(done_w[3]), 32'd0);
    check("u3.restart.err",  32'(err_w[3]),  32'd0);
    wait_done(3, 40, 16);
    check("u3.restart.err_final", 32'(err_w[3]), 32'd1);

    // Stalled cache: Req high exactly 5 cycles, then done+timeout, nothing further.
    kick(4);
    wait_done(4, 30, 6);
    check("u4.timeout", 32'(to_w[4]), 32'd1);
    check("u4.req_cycles", 32'(t_req_cnt), 32'd5);
    repeat (8) @(negedge clk);
    check("u4.req_cycles_later", 32'(t_req_cnt), 32'd5);
    check("u4.req_idle", 32'(b4.Req_CPU), 32'd0);

    // Reset during the second, stalled request.
    push(0, 1'b1, 32'd1, 32'd64, 2'd2, 1);
    kick(0);
    @(negedge clk);
    rdy0 = 1'b0;
    @(negedge clk);
    check("u0.second_req", 32'(b0.Req_CPU), 32'd1);
    check("u0.second_addr", b0.A_CPU, 32'd2);
    rst0 = 1'b0;
    @(negedge clk);
    check_reset_u0("midreset");
    @(negedge clk);
    rst0 = 1'b1;
    rdy0 = 1'b1;
    repeat (4) @(negedge clk);
    check("u0.after_reset.req",  32'(b0.Req_CPU), 32'd0);
    check("u0.after_reset.done", 32'(done_w[0]),  32'd0);

    for (int i = 0; i < 4; i++)
      check($sformatf("u%0d.scoreboard_left", i), 32'(exp_q[i].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
